// File: rtl/partial_sum_sequencer_if.sv
// Signal bundle for partial_sum_sequencer: command, term stream, external adder and result handshake.
// Valid/ready rule: a transfer happens on a rising clk edge where both valid and ready are 1.
interface partial_sum_sequencer_if;
  logic        start;
  logic [2:0]  num_terms;
  logic [35:0] init_value;
  logic        in_valid;
  logic [33:0] in_data;
  logic        in_ready;
  logic [35:0] add_a;
  logic [33:0] add_b;
  logic [36:0] add_sum;
  logic [35:0] result;
  logic        overflow;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  modport master (
    output start, num_terms, init_value, in_valid, in_data, add_sum, result_ready,
    input  in_ready, add_a, add_b, result, overflow, result_valid, busy
  );

  modport slave (
    input  start, num_terms, init_value, in_valid, in_data, add_sum, result_ready,
    output in_ready, add_a, add_b, result, overflow, result_valid, busy
  );
endinterface

// File: rtl/partial_sum_sequencer.sv
// Sequences up to MAX_TERMS 34-bit terms through an external single-cycle adder into a
// 36-bit accumulator with a sticky carry flag, then holds the result until it is taken.
module partial_sum_sequencer #(
  parameter int MAX_TERMS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  partial_sum_sequencer_if.slave  bus,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_TERMS);

  state_t      state;
  logic [35:0] acc;
  logic [2:0]  cnt;
  logic        ovf;
  logic        in_ready_q;
  logic        result_valid_q;
  logic        busy_q;
  logic [2:0]  clamped_terms;

  always_comb begin
    clamped_terms = (bus.num_terms > MAX_CNT) ? MAX_CNT : bus.num_terms;
  end

  // Handshake flags are registered alongside the state so they always decode it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
      in_ready_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= bus.init_value;
            ovf    <= 1'b0;
            busy_q <= 1'b1;
            if (bus.num_terms == 3'd0) begin
              state          <= DONE;
              result_valid_q <= 1'b1;
            end else begin
              cnt        <= clamped_terms;
              state      <= ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc <= bus.add_sum[35:0];
            ovf <= ovf | bus.add_sum[36];
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              state          <= DONE;
              in_ready_q     <= 1'b0;
              result_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state          <= IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          in_ready_q     <= 1'b0;
          result_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  // The adder sits outside; its sum lands in acc on the same edge that accepts the term.
  assign bus.add_a        = acc;
  assign bus.add_b        = in_ready_q ? bus.in_data : 34'd0;
  assign bus.in_ready     = in_ready_q;
  assign bus.result       = acc;
  assign bus.overflow     = ovf;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_partial_sum_sequencer.sv
// Directed bench for partial_sum_sequencer: table of accumulation vectors plus hand-written
// reset and mid-operation abort sequences, with an external adder model.
module tb_partial_sum_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  partial_sum_sequencer_if bus ();

  partial_sum_sequencer #(.MAX_TERMS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  assign bus.add_sum = {1'b0, bus.add_a} + {3'b000, bus.add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] init;
    logic [2:0]  num;
    logic [33:0] term;
    logic [33:0] step;
    int          gap;
    int          hold;
    logic [35:0] exp_result;
    logic        exp_ovf;
    int          exp_accepts;
  } vec_t;

  vec_t        vecs[6];
  logic [35:0] exp_q[$];
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int          accepts;
    int          last;
    int          cyc;
    int          idle;
    bit          got;
    logic [35:0] exp;
    exp_q.push_back(v.exp_result);
    @(negedge clk);
    check("idle_before_start", {62'd0, state_dbg}, 64'd0);
    bus.start      = 1'b1;
    bus.num_terms  = v.num;
    bus.init_value = v.init;
    accepts = 0;
    last    = 0;
    idle    = v.gap;
    got     = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.result_valid) begin
        got = 1'b1;
        break;
      end
      if (bus.in_ready && idle >= v.gap) begin
        bus.in_valid = 1'b1;
        bus.in_data  = v.term + v.step * 34'(accepts);
        accepts++;
        last = cyc;
        idle = 0;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 34'h2_AAAA_5555;
        idle++;
      end
    end
    bus.in_valid = 1'b0;
    check("result_valid_timeout", {63'd0, got}, 64'd1);
    exp = exp_q.pop_front();
    if (got) begin
      check("result_latency", 64'(cyc), 64'((accepts == 0) ? 1 : last + 1));
      check("accept_count", 64'(accepts), 64'(v.exp_accepts));
      check("result_value", {28'd0, bus.result}, {28'd0, exp});
      check("overflow_flag", {63'd0, bus.overflow}, {63'd0, v.exp_ovf});
      check("done_busy", {63'd0, bus.busy}, 64'd1);
      check("done_add_b_zero", {30'd0, bus.add_b}, 64'd0);
      for (int h = 0; h < v.hold; h++) begin
        bus.result_ready = 1'b0;
        bus.start        = (h == 0);
        bus.num_terms    = 3'd1;
        bus.init_value   = 36'h0;
        @(negedge clk);
        bus.start = 1'b0;
        check("hold_valid", {63'd0, bus.result_valid}, 64'd1);
        check("hold_result", {28'd0, bus.result}, {28'd0, exp});
        check("hold_overflow", {63'd0, bus.overflow}, {63'd0, v.exp_ovf});
        check("hold_state_done", {62'd0, state_dbg}, 64'd2);
      end
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
      check("release_valid_low", {63'd0, bus.result_valid}, 64'd0);
      check("release_busy_low", {63'd0, bus.busy}, 64'd0);
      check("release_state_idle", {62'd0, state_dbg}, 64'd0);
      check("idle_result_is_acc", {28'd0, bus.result}, {28'd0, exp});
    end
  endtask

  initial begin
    int rv_seen;
    checks = 0;
    errors = 0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.num_terms    = 3'd0;
    bus.init_value   = 36'h0;
    bus.in_valid     = 1'b1;
    bus.in_data      = 34'h1_2345_6789;
    bus.result_ready = 1'b1;

    vecs[0] = '{36'h0,           3'd4, 34'h3_FFFF_FFFF, 34'd0, 0, 0, 36'hF_FFFF_FFFC, 1'b0, 4};
    vecs[1] = '{36'hF_FFFF_FFFF, 3'd1, 34'd1,           34'd0, 0, 0, 36'h0,          1'b1, 1};
    vecs[2] = '{36'h1_2345_6789, 3'd0, 34'd0,           34'd0, 0, 0, 36'h1_2345_6789, 1'b0, 0};
    vecs[3] = '{36'h0,           3'd7, 34'd5,           34'd0, 2, 3, 36'h14,         1'b0, 4};
    vecs[4] = '{36'hA,           3'd3, 34'h100,         34'd0, 1, 1, 36'h30A,        1'b0, 3};
    vecs[5] = '{36'hF_FFFF_FFF0, 3'd2, 34'h10,          34'd0, 0, 2, 36'h10,         1'b1, 2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {62'd0, state_dbg}, 64'd0);
    check("reset_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("reset_result_valid", {63'd0, bus.result_valid}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_result", {28'd0, bus.result}, 64'd0);
    check("reset_overflow", {63'd0, bus.overflow}, 64'd0);
    check("reset_add_a", {28'd0, bus.add_a}, 64'd0);
    check("reset_add_b", {30'd0, bus.add_b}, 64'd0);
    rst              = 1'b0;
    bus.in_valid     = 1'b0;
    bus.result_ready = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Abort after two of three terms; nothing of that operation may surface.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.num_terms  = 3'd3;
    bus.init_value = 36'h55;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 34'd7;
    check("midop_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    check("midop_add_a_after_one", {28'd0, bus.add_a}, 64'h5C);
    @(negedge clk);
    rst              = 1'b1;
    bus.start        = 1'b1;
    bus.result_ready = 1'b1;
    @(negedge clk);
    rst              = 1'b0;
    bus.start        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.result_ready = 1'b0;
    check("midop_reset_state", {62'd0, state_dbg}, 64'd0);
    check("midop_reset_result", {28'd0, bus.result}, 64'd0);
    check("midop_reset_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rv_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.result_valid) rv_seen++;
    end
    check("midop_no_result_valid", 64'(rv_seen), 64'd0);

    run_op('{36'd5, 3'd2, 34'd1, 34'd1, 0, 0, 36'd8, 1'b0, 2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/partial_sum_sequencer.md
PARTIAL_SUM_SEQUENCER -- requirements
Module: partial_sum_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_TERMS, default 4: the maximum number of 34-bit terms per accumulation; legal values are 1..7.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an accumulation; sampled only in IDLE.
REQ-005 num_terms  input  3  number of terms to accumulate; sampled with start.
REQ-006 init_value  input  36  accumulator seed; sampled with start.
REQ-007 in_valid  input  1  term available on in_data.
REQ-008 in_data  input  34  unsigned term.
REQ-009 in_ready  output  1  block accepts a term this cycle.
REQ-010 add_a  output  36  operand A to the external 36-bit + 34-bit adder.
REQ-011 add_b  output  34  operand B to the external adder; the adder zero-extends it to 36 bits.
REQ-012 add_sum  input  37  adder result; bit 36 is the carry-out.
REQ-013 result  output  36  accumulated sum, modulo 2^36.
REQ-014 overflow  output  1  sticky: set if any add in the operation produced a carry-out.
REQ-015 result_valid  output  1  result and overflow are valid.
REQ-016 result_ready  input  1  consumer accepts the result.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-019 IDLE: when start=1 and num_terms=0, the block SHALL load acc=init_value, clear overflow, and go to DONE.
REQ-020 IDLE: when start=1 and num_terms is nonzero, the block SHALL load acc=init_value, clear overflow, load cnt=min(num_terms, MAX_TERMS), and go to ACCUM.
REQ-021 start SHALL be ignored in ACCUM and DONE.
REQ-022 Adder operands SHALL be combinational: add_a=acc in all states; add_b=in_data in ACCUM, otherwise 0.
REQ-023 in_ready SHALL be 1 exactly when the state is ACCUM.
REQ-024 A term is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-025 On each accepted term: acc <= add_sum[35:0], overflow <= overflow OR add_sum[36], and cnt <= cnt-1.
REQ-026 When a term is accepted with cnt=1, the next state SHALL be DONE.
REQ-027 In ACCUM with in_valid=0, acc, cnt and overflow SHALL hold; there is no timeout.
REQ-028 The adder path is single-cycle: add_sum is consumed in the same cycle add_a/add_b are driven.
REQ-029 No registered stage SHALL exist between the adder and acc.
REQ-030 DONE: result_valid=1, result=acc and overflow SHALL be held stable while result_ready=0.
REQ-031 DONE with result_ready=1: the next state SHALL be IDLE and result_valid SHALL fall next cycle.
REQ-032 Latency: if the last term is accepted in cycle t, result_valid=1 in cycle t+1.
REQ-033 With continuous in_valid, an N-term operation SHALL take N cycles in ACCUM plus at least 1 cycle in DONE.
REQ-034 result SHALL equal acc in all states; result_valid SHALL be 0 outside DONE.
REQ-035 Wrap-around: sums of 2^36 or more SHALL wrap modulo 2^36 with overflow set; no saturation.

Reset
REQ-036 rst=1 at any clock edge SHALL force: state=IDLE, acc=0, cnt=0, overflow=0.
REQ-037 Output values under reset SHALL be: result_valid=0, in_ready=0, busy=0, result=0, add_a=0, add_b=0.
REQ-038 rst SHALL take priority over start, handshakes and result_ready in the same cycle.
REQ-039 Reset mid-operation SHALL discard partial results, and no result_valid SHALL be produced for the aborted operation.

Verification
REQ-040 Reset: hold rst 2 cycles -> all outputs 0; state IDLE; in_ready=0.
REQ-041 Full-width terms: init=0, num_terms=4, four back-to-back terms of 34'h3_FFFF_FFFF -> result=36'hF_FFFF_FFFC, overflow=0, result_valid exactly 1 cycle after the 4th accept.
REQ-042 Wrap: init=36'hF_FFFF_FFFF, num_terms=1, term=1 -> result=0, overflow=1.
REQ-043 Zero terms: num_terms=0, init=36'h1_2345_6789 -> in_ready never asserts; result_valid 1 cycle after start with result=36'h1_2345_6789.
REQ-044 Backpressure and clamp: num_terms=7 with MAX_TERMS=4 -> exactly 4 terms accepted; in_valid gaps of 2 cycles between terms do not change the sum; result_ready low 3 cycles -> result stable, and start pulsed in DONE is ignored.
REQ-045 Mid-op reset: num_terms=3, rst after 2 accepts -> IDLE with no result_valid; next op init=5, num_terms=2, terms 1,2 -> result=8, overflow=0.
